frame_uart_tx: RTL and testbench
================================

# frame_uart_tx

Serializes frames produced by `bit_changer_seq` onto a UART line (8N1-style, LSB first), returning the modified data to the host. It sits directly downstream of `bit_changer_seq`: its `in_enable`/`in_frame` connect to `out_ready`/`out_frame`. It provides one frame of holding buffer so a frame that arrives during transmission is not lost. It flags overflow when a frame arrives and both the active and holding slots are occupied.

## Interface
- `BPS`, 8, bits per word; each word is one UART character with BPS data bits.
- `FRAME_SIZE`, 1, words per frame.
- `CLKS_PER_BIT`, 87, clock cycles per serial bit; must be at least 2.

Ports:
- `in_clk` in 1: single clock; all logic is on its rising edge.
- `in_rst_n` in 1: reset, asynchronous, active-low.
- `in_enable` in 1: one-cycle frame-valid strobe.
- `in_frame` in FRAME_SIZE*BPS: frame data, sampled only when `in_enable`=1. Word k is bits [k*BPS+BPS-1 : k*BPS].
- `out_serial` out 1: UART line; idle level is 1.
- `out_busy` out 1: high from the first start bit until the last stop bit of the final queued frame ends.
- `out_done` out 1: one-cycle pulse when a frame's last stop bit completes.
- `out_overflow` out 1: sticky; set when a frame is dropped; cleared only by reset.

## Operation
- State machine: IDLE, START, DATA, STOP.
- Baud counter counts 0..CLKS_PER_BIT-1; a bit ends when the counter reaches CLKS_PER_BIT-1.
- Bit counter counts 0..BPS-1. Word index counts 0..FRAME_SIZE-1.
- **IDLE:** `out_serial`=1.
  - On `in_enable`, load `in_frame` into the shift register, clear the word index, and go to START.
- **START:** `out_serial`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** drive bit b of word k, LSB first, for CLKS_PER_BIT cycles each. After bit BPS-1, go to STOP.
- **STOP:** `out_serial`=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
  - If the word index is below FRAME_SIZE-1: increment it and go to START. There is no idle gap between words.
  - Otherwise: pulse `out_done`. If the holding register is valid, move it to the shift register, clear the holding-valid flag, and go to START. If not, go to IDLE.
- Frame acceptance while not idle (not IDLE and not in the final-stop end cycle):
  - Holding empty: store the frame in the holding register and set holding-valid.
  - Holding full: drop the frame and set `out_overflow`.
- Final-stop end cycle coinciding with `in_enable`:
  - Holding empty: the new frame goes directly to the shift register, then START.
  - Holding full: the holding frame goes to the shift register and the new frame goes to holding. Nothing is dropped.

## Timing
- Reset values: `out_serial`=1, `out_busy`=0, `out_done`=0, `out_overflow`=0, state IDLE, holding invalid, all counters 0.
- Reset asserted mid-transmission returns `out_serial` to 1 asynchronously. Any partial character is abandoned and not resumed.
- Latency: `in_enable` high in cycle 0 (state IDLE) gives `out_serial`=0 and `out_busy`=1 from cycle 1.
- Frame duration is FRAME_SIZE*(BPS+2)*CLKS_PER_BIT cycles. `out_done` is high in the final cycle of the last stop bit.
- `out_busy` stays high continuously across back-to-back frames taken from holding.
- `out_busy` falls in the cycle after `out_done` if nothing is queued.
- All outputs are registered. `out_serial` never glitches within a bit period.

## Structure
- Shared package holds:
  - the state encoding localparams;
  - the default `CLKS_PER_BIT`, shared with `uart_rx`;
  - the UART idle, start and stop level constants.
- Counter widths use `$clog2` of CLKS_PER_BIT, BPS and FRAME_SIZE, each with a minimum width of 1.
- One sub-module, `uart_tx_word`, contains the baud counter, bit counter and START/DATA/STOP for one BPS-bit character. Its handshake is start strobe in, word-done pulse out.
- `frame_uart_tx` owns the holding buffer, word sequencing, overflow logic and `out_done`.

## Test plan
All scenarios use CLKS_PER_BIT=87 and a 100 ns clock unless noted.
- **Single byte** (FRAME_SIZE=1): `in_frame`=8'h3F with `in_enable` pulse.
  - Required line: 0 for 87 cycles, then bits 1,1,1,1,1,1,0,0 at 87 cycles each, then 1 for 87 cycles.
  - `out_done` fires 870 cycles after the first start-bit cycle.
  - `uart_rx` loopback returns 8'h3F.
- **Two-word frame** (FRAME_SIZE=2): `in_frame`=16'hA55A.
  - Required: characters 8'h5A then 8'hA5, back to back with no idle cycles.
  - A single `out_done` after 1740 cycles.
- **Back-to-back frames:** 8'h11, then 8'h22 during the DATA state of the first.
  - Required: 8'h22 start bit begins the cycle after `out_done`.
  - `out_busy` never drops; two `out_done` pulses.
- **Overflow:** 8'h01, 8'h02, 8'h03 strobed 10 cycles apart.
  - Required: 8'h03 is dropped and `out_overflow`=1 from that strobe onward.
  - Only 8'h01 and 8'h02 are transmitted.
- **Reset mid-operation:** assert `in_rst_n`=0 during bit 3 of 8'hF0.
  - Required: `out_serial`=1, `out_busy`=0, `out_overflow`=0 immediately.
  - After release, 8'hC3 transmits correctly.
- **Chain loopback:** `uart_rx` → `bit_changer_seq` → `frame_uart_tx` → second `uart_rx`.
  - Stimulus: input byte 8'h3F with random message bits.
  - Required: the received byte equals `bit_changer_seq`'s `out_frame`.

Source files
------------

// File: rtl/frame_uart_tx_pkg.sv
// Shared UART definitions for the frame transmitter and its word serializer:
// the serializer state encoding, the default bit period, which uart_rx uses
// as well, and the line levels.
package frame_uart_tx_pkg;

    // Default clock cycles per serial bit. Any override must be at least 2
    // because out_done is registered one cycle ahead of the stop-bit end.
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    // UART line levels.
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    // Serializer state encoding.
    localparam logic [1:0] TX_IDLE_ENC  = 2'd0;
    localparam logic [1:0] TX_START_ENC = 2'd1;
    localparam logic [1:0] TX_DATA_ENC  = 2'd2;
    localparam logic [1:0] TX_STOP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = TX_IDLE_ENC,
        ST_START = TX_START_ENC,
        ST_DATA  = TX_DATA_ENC,
        ST_STOP  = TX_STOP_ENC
    } tx_state_e;

    // Counter width for a 0..n-1 counter. A width of zero would be illegal,
    // so n <= 1 still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : frame_uart_tx_pkg

// File: rtl/frame_uart_tx_word.sv
// Serializes one BPS-bit character as start bit, LSB-first data bits and a
// stop bit. A start strobe in IDLE, or in the final stop-bit cycle, begins
// the next character with no gap between characters.
module uart_tx_word
    import frame_uart_tx_pkg::*;
#(
    parameter int BPS          = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [BPS-1:0] word_i,
    output logic           serial_o,
    output logic           stop_pre_end_o,
    output logic           word_done_o
);

    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_width(BPS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BPS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BPS-1:0]    shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              bit_end;

    // State register. The line register resets to idle level asynchronously.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= UART_IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
        end
    end

    // Next state; the line level is computed for the next cycle so the
    // registered output changes only on bit boundaries.
    // NOTE: every signal gets its default first so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        serial_d    = serial_q;
        word_done_o = 1'b0;
        bit_end     = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                baud_d   = '0;
                serial_d = UART_IDLE_LEVEL;
                if (start_i) begin
                    state_d  = ST_START;
                    shift_d  = word_i;
                    serial_d = UART_START_LEVEL;
                end
            end
            ST_START: begin
                baud_d = baud_q + BAUD_W'(1);
                if (bit_end) begin
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = ST_DATA;
                    serial_d = shift_q[0];
                end
            end
            ST_DATA: begin
                baud_d = baud_q + BAUD_W'(1);
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d  = ST_STOP;
                        serial_d = UART_STOP_LEVEL;
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        shift_d  = shift_q >> 1;
                        serial_d = shift_d[0];
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_q + BAUD_W'(1);
                if (bit_end) begin
                    baud_d      = '0;
                    word_done_o = 1'b1;
                    if (start_i) begin
                        state_d  = ST_START;
                        shift_d  = word_i;
                        serial_d = UART_START_LEVEL;
                    end else begin
                        state_d  = ST_IDLE;
                        serial_d = UART_IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = UART_IDLE_LEVEL;
            end
        endcase
    end

    assign serial_o       = serial_q;
    assign stop_pre_end_o = (state_q == ST_STOP) && (baud_q == BAUD_PRE);

endmodule : uart_tx_word

// File: rtl/frame_uart_tx.sv
// Frame-level UART transmitter: sends FRAME_SIZE words per frame back to
// back, keeps one holding slot for a frame arriving mid-transmission and
// flags a sticky overflow when a frame arrives with both slots occupied.
module frame_uart_tx
    import frame_uart_tx_pkg::*;
#(
    parameter int BPS          = 8,
    parameter int FRAME_SIZE   = 1,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_enable,
    input  logic [FRAME_SIZE*BPS-1:0] in_frame,
    output logic                      out_serial,
    output logic                      out_busy,
    output logic                      out_done,
    output logic                      out_overflow
);

    localparam int FW     = FRAME_SIZE * BPS;
    localparam int WORD_W = cnt_width(FRAME_SIZE);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_SIZE - 1);

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              hold_valid_q, hold_valid_d;
    logic [FW-1:0]     hold_q, hold_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [WORD_W-1:0] word_q, word_d;

    logic              tx_start;
    logic [BPS-1:0]    tx_word;
    logic              tx_pre_end;
    logic              tx_word_done;
    logic              last_word;
    logic              final_end;

    uart_tx_word #(
        .BPS          (BPS),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_word (
        .clk            (in_clk),
        .rst_n          (in_rst_n),
        .start_i        (tx_start),
        .word_i         (tx_word),
        .serial_o       (out_serial),
        .stop_pre_end_o (tx_pre_end),
        .word_done_o    (tx_word_done)
    );

    // Frame bookkeeping registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            frame_q      <= '0;
            word_q       <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            frame_q      <= frame_d;
            word_q       <= word_d;
        end
    end

    // Frame acceptance, holding slot, word sequencing and overflow.
    always_comb begin
        busy_d       = busy_q;
        ovf_d        = ovf_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        frame_d      = frame_q;
        word_d       = word_q;
        tx_start     = 1'b0;

        last_word = (word_q == WORD_LAST);
        final_end = busy_q && tx_word_done && last_word;
        // Registered one cycle early so out_done lands on the last stop cycle.
        done_d    = busy_q && tx_pre_end && last_word;

        if (!busy_q) begin
            if (in_enable) begin
                frame_d  = in_frame;
                word_d   = '0;
                busy_d   = 1'b1;
                tx_start = 1'b1;
            end
        end else if (final_end) begin
            // The serializer restarts in this same cycle, so a queued frame
            // follows with no idle gap and busy never drops.
            if (hold_valid_q) begin
                frame_d  = hold_q;
                word_d   = '0;
                tx_start = 1'b1;
                if (in_enable) begin
                    hold_d = in_frame;
                end else begin
                    hold_valid_d = 1'b0;
                end
            end else if (in_enable) begin
                frame_d  = in_frame;
                word_d   = '0;
                tx_start = 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end else begin
            if (tx_word_done) begin
                word_d   = word_q + WORD_W'(1);
                frame_d  = frame_q >> BPS;
                tx_start = 1'b1;
            end
            if (in_enable) begin
                if (!hold_valid_q) begin
                    hold_d       = in_frame;
                    hold_valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end

        // The word being started is always the low word of the next frame.
        tx_word = frame_d[BPS-1:0];
    end

    assign out_busy     = busy_q;
    assign out_done     = done_q;
    assign out_overflow = ovf_q;

endmodule : frame_uart_tx

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx (two-word frames). A cycle-level reference model
// schedules every accepted frame from the acceptance rules; the expected line
// waveform, busy, done and overflow are derived from that schedule, and a
// UART decoder pops expected characters from a scoreboard queue.
`timescale 1ns/1ps
module tb_frame_uart_tx;

    localparam int BPS      = 8;
    localparam int FS       = 2;
    localparam int CPB      = 87;
    localparam int FW       = FS * BPS;
    localparam int CHAR_CYC = (BPS + 2) * CPB;
    localparam int FC       = FS * CHAR_CYC;
    localparam int NEVER    = 32'h7fff_ffff;

    logic          in_clk    = 1'b0;
    logic          in_rst_n  = 1'b0;
    logic          in_enable = 1'b0;
    logic [FW-1:0] in_frame  = '0;
    logic          out_serial;
    logic          out_busy;
    logic          out_done;
    logic          out_overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int            start;
        logic [FW-1:0] data;
    } ival_t;

    ival_t          ivals[$];     // every scheduled frame since last reset
    int             ends[$];      // end cycles of frames still in flight
    logic [BPS-1:0] exp_chars[$]; // scoreboard of characters to receive
    int             ovf_from = NEVER;

    frame_uart_tx #(
        .BPS          (BPS),
        .FRAME_SIZE   (FS),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_enable    (in_enable),
        .in_frame     (in_frame),
        .out_serial   (out_serial),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_overflow (out_overflow)
    );

    always #50 in_clk = ~in_clk;

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected line level: idle 1; inside a frame, character w = o / CHAR_CYC
    // and bit slot p: 0 = start, 1..BPS = data LSB first, BPS+1 = stop.
    function automatic logic exp_line(input int x);
        logic r;
        r = 1'b1;
        for (int i = 0; i < ivals.size(); i++) begin
            if (x >= ivals[i].start && x < ivals[i].start + FC) begin
                int o, w, p;
                logic [FW-1:0] d;
                o = x - ivals[i].start;
                w = o / CHAR_CYC;
                p = (o % CHAR_CYC) / CPB;
                d = ivals[i].data;
                if (p == 0)            r = 1'b0;
                else if (p == BPS + 1) r = 1'b1;
                else                   r = d[w * BPS + p - 1];
            end
        end
        return r;
    endfunction

    function automatic logic exp_busy(input int x);
        logic r;
        r = 1'b0;
        for (int i = 0; i < ivals.size(); i++)
            if (x >= ivals[i].start && x < ivals[i].start + FC) r = 1'b1;
        return r;
    endfunction

    function automatic logic exp_done(input int x);
        logic r;
        r = 1'b0;
        for (int i = 0; i < ivals.size(); i++)
            if (x == ivals[i].start + FC - 1) r = 1'b1;
        return r;
    endfunction

    // Reference model of a strobe in cycle c: at most one frame in flight
    // plus one waiting; a strobe in the active frame's final cycle finds the
    // active slot freeing up. Returns the end cycle, or -1 when dropped.
    task automatic model_strobe(input int c, input logic [FW-1:0] f, output int end_c);
        ival_t iv;
        while (ends.size() > 0 && ends[0] < c) void'(ends.pop_front());
        end_c = -1;
        if (ends.size() == 0)      end_c = c + FC;
        else if (ends.size() == 1) end_c = ends[0] + FC;
        else if (c == ends[0])     end_c = ends[1] + FC;
        if (end_c < 0) begin
            if (ovf_from > c + 1) ovf_from = c + 1;
        end else begin
            ends.push_back(end_c);
            iv.start = end_c - FC + 1;
            iv.data  = f;
            ivals.push_back(iv);
            for (int w = 0; w < FS; w++) exp_chars.push_back(f[w * BPS +: BPS]);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic strobe(input logic [FW-1:0] f, output int end_c);
        in_enable = 1'b1;
        in_frame  = f;
        model_strobe(cyc, f, end_c);
        tick();
        in_enable = 1'b0;
    endtask

    task automatic assert_reset();
        in_rst_n = 1'b0;
        ivals.delete();
        ends.delete();
        exp_chars.delete();
        ovf_from = NEVER;
    endtask

    // Per-cycle waveform monitor against the model schedule.
    always @(negedge in_clk) begin
        check("serial", 32'(out_serial), 32'(exp_line(cyc)));
        check("busy", 32'(out_busy), 32'(exp_busy(cyc)));
        check("done", 32'(out_done), 32'(exp_done(cyc)));
        check("overflow", 32'(out_overflow), 32'(cyc >= ovf_from));
    end

    // UART decoder: samples mid-bit and pops the scoreboard per character.
    bit             rx_active = 1'b0;
    int             rx_start  = 0;
    logic [BPS-1:0] rx_byte   = '0;

    always @(negedge in_clk) begin
        int off, idx;
        if (!in_rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (out_serial === 1'b0) begin
                rx_active = 1'b1;
                rx_start  = cyc;
            end
        end else begin
            off = cyc - rx_start;
            if (off >= CPB + CPB / 2 && ((off - CPB / 2) % CPB) == 0) begin
                idx = (off - CPB / 2) / CPB - 1;
                if (idx < BPS) begin
                    rx_byte[idx] = out_serial;
                end else begin
                    check("stop_bit", 32'(out_serial), 32'd1);
                    check("rx_char_pending", 32'(exp_chars.size() > 0), 32'd1);
                    if (exp_chars.size() > 0) check("rx_char", 32'(rx_byte), 32'(exp_chars.pop_front()));
                    rx_active = 1'b0;
                end
            end
        end
    end

    initial begin
        int e1, e2, e3, tgt;
        logic [FW-1:0] f;

        // Reset state.
        repeat (3) tick();
        check("rst_serial", 32'(out_serial), 32'd1);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        in_rst_n = 1'b1;
        repeat (5) tick();

        // Two-word frame: 5A then A5 back to back, one done.
        strobe(16'hA55A, e1);
        wait_until(e1 + 10);

        // Back-to-back frames, second arrives during DATA of the first.
        strobe(16'h1111, e1);
        repeat (300) tick();
        strobe(16'h2222, e2);
        check("b2b_accepted", 32'(e2), 32'(e1 + FC));
        wait_until(e2 + 10);

        // Strobe exactly in the final stop cycle, holding empty.
        strobe(16'h5AC3, e1);
        wait_until(e1);
        strobe(16'h7E81, e2);
        wait_until(e2 + 10);

        // Strobe exactly in the final stop cycle, holding full: no drop.
        strobe(16'h1234, e1);
        repeat (50) tick();
        strobe(16'h5678, e2);
        wait_until(e1);
        strobe(16'h9ABC, e3);
        check("end_cycle_full_accepted", 32'(e3), 32'(e2 + FC));
        wait_until(e3 + 10);
        check("no_overflow_yet", 32'(out_overflow), 32'd0);

        // Overflow: third frame dropped, sticky flag set from then on.
        strobe(16'h0001, e1);
        repeat (9) tick();
        strobe(16'h0002, e2);
        repeat (9) tick();
        strobe(16'h0003, e3);
        check("overflow_drop", 32'(e3), 32'hffff_ffff);
        check("overflow_set", 32'(out_overflow), 32'd1);
        wait_until(e2 + 10);
        check("overflow_sticky", 32'(out_overflow), 32'd1);

        // Reset during data bit 3 of F0.
        strobe(16'h00F0, e1);
        tgt = (e1 - FC + 1) + CPB * 4 + CPB / 2;
        wait_until(tgt);
        assert_reset();
        #1;
        check("midrst_serial", 32'(out_serial), 32'd1);
        check("midrst_busy", 32'(out_busy), 32'd0);
        check("midrst_overflow", 32'(out_overflow), 32'd0);
        repeat (4) tick();
        in_rst_n = 1'b1;
        repeat (3) tick();
        strobe(16'h3CC3, e1);
        wait_until(e1 + 10);

        // Randomized traffic, sometimes aimed at a final stop cycle.
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 2000)) tick();
            if ($urandom_range(0, 3) == 0) begin
                for (int i = ends.size() - 1; i >= 0; i--)
                    if (ends[i] >= cyc) tgt = ends[i];
                if (ends.size() > 0 && ends[ends.size() - 1] >= cyc) wait_until(tgt);
            end
            f = FW'($urandom());
            strobe(f, e1);
        end

        if (ends.size() > 0) wait_until(ends[ends.size() - 1] + 2 * CPB);
        else repeat (2 * CPB) tick();
        check("chars_drained", 32'(exp_chars.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_frame_uart_tx
